// File: rtl/axil_master.sv
// AXI-Lite initiator: single-beat command/response front end with one outstanding
// transaction and a sticky response-phase watchdog.
module axil_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic                  timeout_err,
    output logic [ADDR_WIDTH-1:0] m_axi_aw_addr,
    output logic                  m_axi_aw_valid,
    input  logic                  m_axi_aw_ready,
    output logic [DATA_WIDTH-1:0] m_axi_w_data,
    output logic                  m_axi_w_valid,
    input  logic                  m_axi_w_ready,
    input  logic [1:0]            m_axi_b_resp,
    input  logic                  m_axi_b_valid,
    output logic                  m_axi_b_ready,
    output logic [ADDR_WIDTH-1:0] m_axi_ar_addr,
    output logic                  m_axi_ar_valid,
    input  logic                  m_axi_ar_ready,
    input  logic [DATA_WIDTH-1:0] m_axi_r_data,
    input  logic [1:0]            m_axi_r_resp,
    input  logic                  m_axi_r_valid,
    output logic                  m_axi_r_ready
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic WD_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR_DATA, WAIT_B, RD_ADDR, WAIT_R, RSP, HALT
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  aw_valid_q, aw_valid_d;
    logic                  w_valid_q, w_valid_d;
    logic                  ar_valid_q, ar_valid_d;
    logic                  b_ready_q, b_ready_d;
    logic                  r_ready_q, r_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  timeout_err_q, timeout_err_d;
    logic [CW-1:0]         wd_cnt_q, wd_cnt_d;
    logic                  aw_done, w_done, wd_expire;

    always_comb begin
        aw_done   = !aw_valid_q || m_axi_aw_ready;
        w_done    = !w_valid_q || m_axi_w_ready;
        wd_expire = WD_EN && (wd_cnt_q == WD_LAST);
    end

    // Next-state and next-output computation; every register defaults to hold.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        aw_valid_d    = aw_valid_q;
        w_valid_d     = w_valid_q;
        ar_valid_d    = ar_valid_q;
        b_ready_d     = b_ready_q;
        r_ready_d     = r_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        timeout_err_d = timeout_err_q;
        wd_cnt_d      = wd_cnt_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    if (cmd_write) begin
                        wdata_d    = cmd_wdata;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        state_d    = WR_ADDR_DATA;
                    end else begin
                        ar_valid_d = 1'b1;
                        state_d    = RD_ADDR;
                    end
                end
            end
            WR_ADDR_DATA: begin
                if (aw_valid_q && m_axi_aw_ready) aw_valid_d = 1'b0;
                if (w_valid_q && m_axi_w_ready)   w_valid_d  = 1'b0;
                if (aw_done && w_done) begin
                    b_ready_d = 1'b1;
                    wd_cnt_d  = '0;
                    state_d   = WAIT_B;
                end
            end
            RD_ADDR: begin
                if (m_axi_ar_ready) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    wd_cnt_d   = '0;
                    state_d    = WAIT_R;
                end
            end
            WAIT_B, WAIT_R: begin
                // A handshake in the expiry cycle takes priority over the watchdog.
                if ((state_q == WAIT_B) ? m_axi_b_valid : m_axi_r_valid) begin
                    b_ready_d     = 1'b0;
                    r_ready_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (state_q == WAIT_B) ? '0 : m_axi_r_data;
                    rsp_resp_d    = (state_q == WAIT_B) ? m_axi_b_resp : m_axi_r_resp;
                    state_d       = RSP;
                end else if (wd_expire) begin
                    b_ready_d     = 1'b0;
                    r_ready_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = 2'b10;
                    timeout_err_d = 1'b1;
                    state_d       = RSP;
                end else if (WD_EN) begin
                    wd_cnt_d = wd_cnt_q + CW'(1);
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = rsp_timeout_q ? HALT : IDLE;
                end
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            cmd_ready_q   <= 1'b1;
            aw_valid_q    <= 1'b0;
            w_valid_q     <= 1'b0;
            ar_valid_q    <= 1'b0;
            b_ready_q     <= 1'b0;
            r_ready_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
            timeout_err_q <= 1'b0;
            wd_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            cmd_ready_q   <= cmd_ready_d;
            aw_valid_q    <= aw_valid_d;
            w_valid_q     <= w_valid_d;
            ar_valid_q    <= ar_valid_d;
            b_ready_q     <= b_ready_d;
            r_ready_q     <= r_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            timeout_err_q <= timeout_err_d;
            wd_cnt_q      <= wd_cnt_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_resp       = rsp_resp_q;
    assign rsp_timeout    = rsp_timeout_q;
    assign timeout_err    = timeout_err_q;
    assign m_axi_aw_addr  = addr_q;
    assign m_axi_aw_valid = aw_valid_q;
    assign m_axi_w_data   = wdata_q;
    assign m_axi_w_valid  = w_valid_q;
    assign m_axi_b_ready  = b_ready_q;
    assign m_axi_ar_addr  = addr_q;
    assign m_axi_ar_valid = ar_valid_q;
    assign m_axi_r_ready  = r_ready_q;

endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master with a 16-cycle watchdog; the bench plays the AXI-Lite slave.
module tb_axil_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout, timeout_err;
    logic [31:0] aw_addr, w_data, ar_addr, r_data;
    logic        aw_valid, aw_ready, w_valid, w_ready;
    logic [1:0]  b_resp, r_resp;
    logic        b_valid, b_ready, ar_valid, ar_ready, r_valid, r_ready;

    int checks = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    axil_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .timeout_err(timeout_err),
        .m_axi_aw_addr(aw_addr), .m_axi_aw_valid(aw_valid), .m_axi_aw_ready(aw_ready),
        .m_axi_w_data(w_data), .m_axi_w_valid(w_valid), .m_axi_w_ready(w_ready),
        .m_axi_b_resp(b_resp), .m_axi_b_valid(b_valid), .m_axi_b_ready(b_ready),
        .m_axi_ar_addr(ar_addr), .m_axi_ar_valid(ar_valid), .m_axi_ar_ready(ar_ready),
        .m_axi_r_data(r_data), .m_axi_r_resp(r_resp), .m_axi_r_valid(r_valid),
        .m_axi_r_ready(r_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic wr, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
        aw_ready = 0; w_ready = 0; b_resp = 0; b_valid = 0;
        ar_ready = 0; r_data = 0; r_resp = 0; r_valid = 0;
        #12;
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_aw_valid", aw_valid, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_timeout_err", timeout_err, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Write 0x08 <- 3, both ready, B after 2 cycles
        cmd(1, 32'h08, 32'h3); aw_ready = 1; w_ready = 1;
        tick(); cmd_valid = 0;
        chk("w1_aw_valid", aw_valid, 1);
        chk("w1_w_valid", w_valid, 1);
        chk("w1_aw_addr", aw_addr, 32'h08);
        chk("w1_w_data", w_data, 32'h3);
        chk("w1_cmd_ready", cmd_ready, 0);
        tick();
        chk("w1_aw_drop", aw_valid, 0);
        chk("w1_w_drop", w_valid, 0);
        chk("w1_b_ready", b_ready, 1);
        tick();
        chk("w1_no_rsp_yet", rsp_valid, 0);
        b_valid = 1; b_resp = 2'b00;
        tick(); b_valid = 0;
        chk("w1_rsp_valid", rsp_valid, 1);
        chk("w1_rsp_resp", rsp_resp, 0);
        chk("w1_rsp_rdata", rsp_rdata, 0);
        chk("w1_b_ready_low", b_ready, 0);
        rsp_ready = 1;
        tick(); rsp_ready = 0;
        chk("w1_rsp_done", rsp_valid, 0);
        chk("w1_cmd_ready", cmd_ready, 1);

        // Write 0x04 <- 0x1C, W accepted first, AW late
        cmd(1, 32'h04, 32'h1C); aw_ready = 0; w_ready = 1;
        tick(); cmd_valid = 0;
        chk("w2_both_valid", {aw_valid, w_valid}, 2'b11);
        tick(); w_ready = 0;
        chk("w2_w_dropped", {aw_valid, w_valid}, 2'b10);
        chk("w2_b_ready_wait", b_ready, 0);
        tick(); tick();
        chk("w2_aw_held", aw_valid, 1);
        chk("w2_aw_addr_stable", aw_addr, 32'h04);
        aw_ready = 1;
        tick(); aw_ready = 0;
        chk("w2_aw_dropped", aw_valid, 0);
        chk("w2_b_ready", b_ready, 1);
        b_valid = 1; b_resp = 2'b01;
        tick(); b_valid = 0;
        chk("w2_rsp_resp", rsp_resp, 2'b01);
        rsp_ready = 1;
        tick(); rsp_ready = 0;
        tick();
        chk("w2_single_rsp", rsp_valid, 0);

        // Read 0x08, R after 3 cycles, response back-pressured 5 cycles
        cmd(0, 32'h08, 32'h0); ar_ready = 1;
        tick(); cmd_valid = 0;
        chk("r1_ar_valid", ar_valid, 1);
        chk("r1_ar_addr", ar_addr, 32'h08);
        tick(); ar_ready = 0;
        chk("r1_ar_drop", ar_valid, 0);
        chk("r1_r_ready", r_ready, 1);
        tick(); tick();
        r_valid = 1; r_data = 32'hDEAD_BEEF; r_resp = 2'b00;
        tick(); r_valid = 0; r_data = 0;
        for (int i = 0; i < 5; i++) begin
            chk("r1_rsp_hold_valid", rsp_valid, 1);
            chk("r1_rsp_hold_rdata", rsp_rdata, 32'hDEAD_BEEF);
            chk("r1_cmd_ready_low", cmd_ready, 0);
            tick();
        end
        rsp_ready = 1;
        tick(); rsp_ready = 0;
        chk("r1_rsp_done", rsp_valid, 0);
        chk("r1_idle", cmd_ready, 1);

        // Read with R arriving in the 16th WAIT_R cycle: normal response
        cmd(0, 32'h0C, 32'h0); ar_ready = 1;
        tick(); cmd_valid = 0;
        tick(); ar_ready = 0;
        for (int i = 0; i < 15; i++) tick();
        chk("r2_r_ready_c16", r_ready, 1);
        chk("r2_no_rsp_yet", rsp_valid, 0);
        r_valid = 1; r_data = 32'h1234_5678; r_resp = 2'b00;
        tick(); r_valid = 0;
        chk("r2_rsp_valid", rsp_valid, 1);
        chk("r2_rsp_timeout", rsp_timeout, 0);
        chk("r2_rsp_resp", rsp_resp, 0);
        chk("r2_rsp_rdata", rsp_rdata, 32'h1234_5678);
        chk("r2_timeout_err", timeout_err, 0);
        rsp_ready = 1;
        tick(); rsp_ready = 0;
        chk("r2_idle", cmd_ready, 1);

        // Read that never completes: watchdog fires after 16 r_ready cycles
        cmd(0, 32'h10, 32'h0); ar_ready = 1;
        tick(); cmd_valid = 0;
        tick(); ar_ready = 0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) break;
            if (r_ready) n++;
            tick();
        end
        chk("to_r_ready_cycles", n, 16);
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_resp", rsp_resp, 2'b10);
        chk("to_rsp_timeout", rsp_timeout, 1);
        chk("to_rsp_rdata", rsp_rdata, 0);
        chk("to_timeout_err", timeout_err, 1);
        rsp_ready = 1;
        tick(); rsp_ready = 0;
        chk("to_halt_cmd_ready", cmd_ready, 0);
        cmd(0, 32'h14, 32'h0); ar_ready = 1; r_valid = 1;
        tick(); tick();
        chk("to_halt_ar_valid", ar_valid, 0);
        chk("to_halt_r_ready", r_ready, 0);
        chk("to_halt_rsp_valid", rsp_valid, 0);
        chk("to_sticky_err", timeout_err, 1);
        cmd_valid = 0; ar_ready = 0; r_valid = 0;

        // Reset clears HALT, then abort a write mid-flight
        rst_n = 0;
        #1;
        chk("rst1_timeout_err", timeout_err, 0);
        tick(); rst_n = 1;
        chk("rst1_cmd_ready", cmd_ready, 1);
        cmd(1, 32'h20, 32'h55); aw_ready = 0; w_ready = 0;
        tick(); cmd_valid = 0;
        chk("rst2_aw_valid_pre", aw_valid, 1);
        #2 rst_n = 0;
        #1;
        chk("rst2_valids_async", {aw_valid, w_valid, ar_valid, b_ready, r_ready}, 5'b0);
        chk("rst2_cmd_ready", cmd_ready, 1);
        tick(); rst_n = 1;
        tick();
        chk("rst2_cmd_ready_after", cmd_ready, 1);
        chk("rst2_no_rsp", rsp_valid, 0);
        cmd(1, 32'h00, 32'hA5); aw_ready = 1; w_ready = 1;
        tick(); cmd_valid = 0;
        chk("w3_aw_addr", aw_addr, 32'h00);
        chk("w3_w_data", w_data, 32'hA5);
        tick(); aw_ready = 0; w_ready = 0;
        chk("w3_b_ready", b_ready, 1);
        b_valid = 1; b_resp = 2'b00;
        tick(); b_valid = 0;
        chk("w3_rsp", {rsp_valid, rsp_resp, rsp_timeout}, 4'b1000);
        rsp_ready = 1;
        tick(); rsp_ready = 0;
        chk("w3_idle", cmd_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axil_master.md
Name: axil_master

Overview:
AXI-Lite initiator that turns a simple single-beat command/response interface into AXI-Lite write and read transactions. It is the host-side counterpart of the accelerator's AXI-Lite control slave. It is used by the on-chip config sequencer and testbenches to program the control, width and ksize registers and read them back. One transaction is outstanding at a time, and a response-phase watchdog latches a sticky error.

Parameters:
ADDR_WIDTH, 32, width of the command address and the AW/AR address buses
DATA_WIDTH, 32, width of the command data, W data and R data buses
TIMEOUT_CYCLES, 1024, cycles allowed in the B or R wait phase before a timeout; 0 disables the watchdog

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when high together with cmd_valid
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  target byte address
cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_resp  out  2  AXI resp code (B or R), or 2'b10 on timeout
rsp_timeout  out  1  response was generated by the watchdog
timeout_err  out  1  sticky; set on timeout, cleared only by reset
m_axi_aw_addr  out  ADDR_WIDTH  write address
m_axi_aw_valid  out  1
m_axi_aw_ready  in  1
m_axi_w_data  out  DATA_WIDTH  write data
m_axi_w_valid  out  1
m_axi_w_ready  in  1
m_axi_b_resp  in  2
m_axi_b_valid  in  1
m_axi_b_ready  out  1
m_axi_ar_addr  out  ADDR_WIDTH  read address
m_axi_ar_valid  out  1
m_axi_ar_ready  in  1
m_axi_r_data  in  DATA_WIDTH
m_axi_r_resp  in  2
m_axi_r_valid  in  1
m_axi_r_ready  out  1

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all valid/ready outputs 0 except cmd_ready; address, data, rsp_* registers 0; timeout_err 0; watchdog counter 0.
- States: IDLE, WR_ADDR_DATA, WAIT_B, RD_ADDR, WAIT_R, RSP, HALT. cmd_ready = (state == IDLE), registered-state decode.
- IDLE: on cmd_valid && cmd_ready, latch addr/wdata/write.
  - write: next cycle go to WR_ADDR_DATA with aw_valid=w_valid=1.
  - read: next cycle go to RD_ADDR with ar_valid=1.
  - Command-to-valid latency is 1 cycle.
- WR_ADDR_DATA: aw_valid and w_valid are independent. Each drops the cycle after its own handshake. Address and data stay stable while valid. Enter WAIT_B once both handshakes are done, including the case where both happen in the same cycle. Either order is legal.
- RD_ADDR: hold ar_valid until ar_ready, then go to WAIT_R.
- WAIT_B: b_ready=1. On b_valid, capture b_resp, set rsp_rdata=0, go to RSP.
- WAIT_R: r_ready=1. On r_valid, capture r_data/r_resp, go to RSP.
- No valid is ever withdrawn before its handshake. b_ready/r_ready are only high in WAIT_B/WAIT_R.
- RSP: rsp_valid=1 and rsp_* stay stable until rsp_ready. Return to IDLE the cycle after the handshake. Back-to-back commands therefore have ≥1 idle cycle between rsp handshake and the next cmd accept.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter clears on entry to WAIT_B/WAIT_R and increments each cycle without a B/R handshake.
  - When count == TIMEOUT_CYCLES-1 with no handshake, the next state is RSP with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0, and timeout_err is set.
  - After that rsp handshake the block enters HALT: cmd_ready=0 and all AXI valid/ready are 0 until reset. This prevents a late response from being matched to a new command.
  - The AW/W/AR phases are not timed, since AXI forbids withdrawing valid.
- A handshake in the same cycle as expiry wins: it is a normal response.
- Reset mid-transaction aborts immediately. All outputs take their reset values, with no completion of the pending handshake.

Test Plan:
- Write 0x08 ← 0x0000_0003, aw_ready=w_ready=1, b_resp=00 after 2 cycles -> aw/w valid 1 cycle after accept; rsp_valid with rsp_resp=00, rsp_rdata=0.
- Write 0x04 ← 0x1C: w_ready at cycle 1, aw_ready at cycle 4 -> w_valid drops after cycle 1, aw_valid held to cycle 4, b_ready only after both; single response.
- Read 0x08, slave r_data=0xDEAD_BEEF r_resp=00 after 3 cycles -> rsp_rdata=0xDEADBEEF; rsp_ready held low 5 cycles -> rsp stable, cmd_ready=0 throughout.
- TIMEOUT_CYCLES=16, read with r_valid never asserted -> r_ready high exactly 16 cycles; rsp_resp=10, rsp_timeout=1, timeout_err=1; after rsp handshake cmd_ready stays 0.
- Read with r_valid asserted in the same cycle as expiry (TIMEOUT_CYCLES=16, r_valid in 16th WAIT_R cycle) -> normal response, rsp_timeout=0, timeout_err=0.
- Assert rst_n low while aw_valid=1 -> all valids 0 asynchronously; after release cmd_ready=1, and a following write to 0x00 completes normally.
